camera_capture: RTL and testbench

Converts the OV7670 8-bit parallel pixel bus into 12-bit RGB444 pixel writes for the frame buffer. Runs entirely in the camera pixel-clock domain. Pairs consecutive bytes within each `href` line into one pixel and generates a linear frame-buffer write address. Drives the write port of the dual-clock frame RAM directly.

---
 rtl/camera_capture.sv | 198 +++++++++++++++++++
 tb/tb_camera_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// camera_capture
//   Turns the OV7670 8-bit parallel pixel bus into 12-bit RGB444 pixel
//   writes for the frame buffer. Consecutive byte pairs inside an HREF
//   line become one pixel; a linear write address is generated per frame.
//   Lives entirely in the camera PCLK domain and drives the write port of
//   the dual-clock frame RAM directly.
//
// Ports
//   clk_i            camera PCLK, inputs sampled on the rising edge
//   reset_i          asynchronous active-high reset
//   vsync_i          camera VSYNC (high = vertical blanking)
//   href_i           camera HREF (high = valid line bytes)
//   data_i[7:0]      camera data byte
//   pixel_valid_o    one-cycle frame RAM write enable
//   pixel_address_o  frame RAM write address (holds between writes)
//   pixel_data_o     pixel {R,G,B} (holds between writes)
//   frame_done_o     one-cycle pulse at end of a non-empty frame
//   overflow_o       sticky: current frame exceeded DEPTH pixels
//
// Build option
//   CAPTURE_TEST_PATTERN_EN  replaces camera pixel data with eight vertical
//                            colour bars chosen by column bits [8:6].
module camera_capture #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 76800,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  vsync_i,
  input  logic                  href_i,
  input  logic [7:0]            data_i,
  output logic                  pixel_valid_o,
  output logic [ADDR_WIDTH-1:0] pixel_address_o,
  output logic [WIDTH-1:0]      pixel_data_o,
  output logic                  frame_done_o,
  output logic                  overflow_o
);

  // One extra bit so the count can saturate at DEPTH even when
  // DEPTH == 2**ADDR_WIDTH.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {SYNC, FRAME} state_t;

  state_t state_reg, state_next;

  logic vsync_reg, vsync_prev_reg, href_reg;
  logic [7:0] data_reg;
  logic vsync_fall, vsync_rise;

  logic phase_low_reg, phase_low_next;
  logic [3:0] red_reg, red_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic overflow_reg, overflow_next;
  logic done_pend_reg, done_pend_next;
  logic low_byte;

  logic pixel_valid_reg, pixel_valid_next;
  logic [ADDR_WIDTH-1:0] pixel_address_reg, pixel_address_next;
  logic [WIDTH-1:0] pixel_data_reg, pixel_data_next;
  logic frame_done_reg, frame_done_next;
  logic [WIDTH-1:0] pixel_word;

  assign vsync_fall = vsync_prev_reg & ~vsync_reg;
  assign vsync_rise = ~vsync_prev_reg & vsync_reg;

`ifdef CAPTURE_TEST_PATTERN_EN
  // Column = pixel index within the current line (bytes-in-line / 2).
  logic [9:0] col_reg;
  logic [2:0] bar;
  logic [11:0] pattern;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_reg <= '0;
    end else if (state_reg != FRAME || !href_reg || vsync_fall) begin
      col_reg <= '0;
    end else if (phase_low_reg) begin
      col_reg <= col_reg + 10'd1;
    end
  end

  assign bar = col_reg[8:6];
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar
    assign pattern[gi*4 +: 4] = {4{bar[gi]}};
  end
  assign pixel_word = WIDTH'(pattern);
`else
  assign pixel_word = WIDTH'({red_reg, data_reg});
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vsync_reg         <= 1'b0;
      vsync_prev_reg    <= 1'b0;
      href_reg          <= 1'b0;
      data_reg          <= '0;
      state_reg         <= SYNC;
      phase_low_reg     <= 1'b0;
      red_reg           <= '0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
      done_pend_reg     <= 1'b0;
      pixel_valid_reg   <= 1'b0;
      pixel_address_reg <= '0;
      pixel_data_reg    <= '0;
      frame_done_reg    <= 1'b0;
    end else begin
      vsync_reg         <= vsync_i;
      vsync_prev_reg    <= vsync_reg;
      href_reg          <= href_i;
      data_reg          <= data_i;
      state_reg         <= state_next;
      phase_low_reg     <= phase_low_next;
      red_reg           <= red_next;
      count_reg         <= count_next;
      overflow_reg      <= overflow_next;
      done_pend_reg     <= done_pend_next;
      pixel_valid_reg   <= pixel_valid_next;
      pixel_address_reg <= pixel_address_next;
      pixel_data_reg    <= pixel_data_next;
      frame_done_reg    <= frame_done_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    phase_low_next     = phase_low_reg;
    red_next           = red_reg;
    count_next         = count_reg;
    overflow_next      = overflow_reg;
    done_pend_next     = 1'b0;
    pixel_valid_next   = 1'b0;
    pixel_address_next = pixel_address_reg;
    pixel_data_next    = pixel_data_reg;
    // A deferred end-of-frame (rise coincided with a pixel) fires now.
    frame_done_next    = done_pend_reg;
    low_byte           = 1'b0;

    case (state_reg)
      SYNC: begin
        phase_low_next = 1'b0;
        count_next     = '0;
        overflow_next  = 1'b0;
        if (vsync_fall) begin
          state_next = FRAME;
        end
      end
      FRAME: begin
        if (vsync_fall) begin
          count_next     = '0;
          overflow_next  = 1'b0;
          phase_low_next = 1'b0;
        end else begin
          if (href_reg) begin
            if (!phase_low_reg) begin
              red_next       = data_reg[3:0];
              phase_low_next = 1'b1;
            end else begin
              phase_low_next = 1'b0;
              low_byte       = 1'b1;
              if (count_reg < DEPTH_C) begin
                pixel_valid_next   = 1'b1;
                pixel_address_next = count_reg[ADDR_WIDTH-1:0];
                pixel_data_next    = pixel_word;
                count_next         = count_reg + CNT_W'(1);
              end else begin
                overflow_next = 1'b1;
              end
            end
          end else begin
            // Dropping href discards any dangling HIGH byte.
            phase_low_next = 1'b0;
          end
          if (vsync_rise) begin
            // The pixel completing on this cycle is written first and the
            // frame is then non-empty, so the pulse just slips one cycle.
            if (low_byte) begin
              done_pend_next = 1'b1;
            end else if (count_reg != '0) begin
              frame_done_next = 1'b1;
            end
          end
        end
      end
      default: state_next = SYNC;
    endcase
  end

  assign pixel_valid_o   = pixel_valid_reg;
  assign pixel_address_o = pixel_address_reg;
  assign pixel_data_o    = pixel_data_reg;
  assign frame_done_o    = frame_done_reg;
  assign overflow_o      = overflow_reg;

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;

  localparam int DEPTH_TB = 128;
  localparam int AW       = 17;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic vsync_i = 1'b0;
  logic href_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic pixel_valid_o;
  logic [AW-1:0] pixel_address_o;
  logic [11:0] pixel_data_o;
  logic frame_done_o;
  logic overflow_o;

  camera_capture #(
    .WIDTH(12),
    .DEPTH(DEPTH_TB),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .vsync_i(vsync_i),
    .href_i(href_i),
    .data_i(data_i),
    .pixel_valid_o(pixel_valid_o),
    .pixel_address_o(pixel_address_o),
    .pixel_data_o(pixel_data_o),
    .frame_done_o(frame_done_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         addr;
    logic [11:0] data;
    int         at;
  } pix_t;

  pix_t pix_q[$];
  int   done_q[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [11:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo, input int col);
`ifdef CAPTURE_TEST_PATTERN_EN
    logic [2:0] b;
    b = 3'(col >> 6);
    return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
`else
    return {hi[3:0], lo};
`endif
  endfunction

  // Monitor: pops expected writes / frame-done pulses and compares.
  always @(negedge clk_i) begin
    pix_t e;
    int d;
    while (pix_q.size() > 0 && pix_q[0].at < cyc) begin
      e = pix_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missed_write: no pixel_valid_o by cycle %0d, required addr %0d data %03h", e.at, e.addr, e.data);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      d = done_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missed_frame_done: no pulse at cycle %0d", d);
    end
    if (pixel_valid_o === 1'b1) begin
      compared++;
      if (pix_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: cycle %0d addr %0d data %03h, required no write", cyc, pixel_address_o, pixel_data_o);
      end else begin
        e = pix_q.pop_front();
        if (e.at != cyc || pixel_address_o !== AW'(e.addr) || pixel_data_o !== e.data) begin
          mismatched++;
          $display("FAIL pixel_write: got cycle %0d addr %0d data %03h, required cycle %0d addr %0d data %03h",
                   cyc, pixel_address_o, pixel_data_o, e.at, e.addr, e.data);
        end else begin
          $display("write  cycle %0d addr %0d data %03h ok", cyc, pixel_address_o, pixel_data_o);
        end
      end
    end
    if (frame_done_o === 1'b1) begin
      compared++;
      if (done_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_frame_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        d = done_q.pop_front();
        if (d != cyc) begin
          mismatched++;
          $display("FAIL frame_done_time: got cycle %0d, required cycle %0d", cyc, d);
        end else begin
          $display("done   cycle %0d ok", cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check  %s = %0h ok", name, act);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] d);
    vsync_i = v;
    href_i  = h;
    data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  // One pixel: HIGH byte then LOW byte. Optionally raise vsync together
  // with the LOW byte (pixel first, frame_done one cycle later).
  task automatic pixel(input logic [7:0] hi, input logic [7:0] lo, input int col,
                       input bit wr, input int addr, input bit rise_on_low);
    int c;
    step(1'b0, 1'b1, hi);
    c = cyc;
    if (wr) pix_q.push_back('{addr, exp_pix(hi, lo, col), c + 2});
    if (rise_on_low) done_q.push_back(c + 3);
    step(rise_on_low, 1'b1, lo);
  endtask

  task automatic vs_rise(input bit exp_done);
    if (exp_done) done_q.push_back(cyc + 2);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic vs_fall();
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: bench did not finish in time");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_valid", 32'(pixel_valid_o), 32'd0);
    check("reset_addr", 32'(pixel_address_o), 32'd0);
    check("reset_data", 32'(pixel_data_o), 32'd0);
    check("reset_done", 32'(frame_done_o), 32'd0);
    check("reset_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Bytes before any vsync fall are ignored
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i));
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("presync_valid", 32'(pixel_valid_o), 32'd0);
    check("presync_addr", 32'(pixel_address_o), 32'd0);
    check("presync_data", 32'(pixel_data_o), 32'd0);

    // Frame 1: rise in SYNC gives no frame_done
    vs_rise(1'b0);
    step(1'b1, 1'b0, 8'h00);
    vs_fall();
    pixel(8'h0A, 8'h5C, 0, 1'b1, 0, 1'b0);
    pixel(8'h03, 8'hE7, 1, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    // Odd line: third byte dropped
    pixel(8'h46, 8'h9B, 0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b1, 8'h77);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    pixel(8'h01, 8'h23, 0, 1'b1, 3, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    vs_rise(1'b1);
    repeat (2) step(1'b1, 1'b0, 8'h00);
    vs_fall();

    // Full frame plus two overflowing pixels in one line
    for (int i = 0; i < DEPTH_TB + 2; i++)
      pixel(8'(i * 7 + 1), 8'(i * 13 + 5), i, i < DEPTH_TB, i, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("overflow_set", 32'(overflow_o), 32'd1);
    check("last_addr_held", 32'(pixel_address_o), 32'(DEPTH_TB - 1));
    vs_rise(1'b1);
    repeat (2) step(1'b1, 1'b0, 8'h00);
    check("overflow_sticky", 32'(overflow_o), 32'd1);
    vs_fall();
    check("overflow_cleared", 32'(overflow_o), 32'd0);

    // vsync rise together with a LOW byte
    pixel(8'h12, 8'h34, 0, 1'b1, 0, 1'b0);
    pixel(8'h56, 8'h78, 1, 1'b1, 1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    vs_fall();

    // Reset mid-line at pixel 100
    for (int i = 0; i < 100; i++)
      pixel(8'(i + 3), 8'(i * 5), i, 1'b1, i, 1'b0);
    step(1'b0, 1'b1, 8'hC4);
    @(negedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    check("midreset_valid", 32'(pixel_valid_o), 32'd0);
    check("midreset_addr", 32'(pixel_address_o), 32'd0);
    check("midreset_data", 32'(pixel_data_o), 32'd0);
    check("midreset_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h50 + i));
    step(1'b0, 1'b0, 8'h00);
    vs_rise(1'b0);
    step(1'b1, 1'b0, 8'h00);
    vs_fall();
    pixel(8'h9A, 8'hBC, 0, 1'b1, 0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'h00);

    check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
